multiplier_iterative_param: RTL and testbench

Parametrised, handshaked iterative shift-add multiplier, the successor to the fixed 32-bit iterative multiplier in the functional-units lab. It multiplies two WIDTH-bit operands, either signed or unsigned, into a 2·WIDTH-bit product. It retires STEP multiplier bits per cycle and can optionally terminate early. It uses valid/ready flow control on both sides, so it can sit between a register-read stage and a writeback queue that may apply backpressure.

---
 rtl/multiplier_iterative_param_pkg.sv | 19 +
 rtl/multiplier_iterative_param_if.sv | 23 ++
 rtl/multiplier_iterative_param_step.sv | 26 ++
 rtl/multiplier_iterative_param.sv | 106 ++++++++++
 tb/tb_multiplier_iterative_param.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/multiplier_iterative_param_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit step_is_legal(input int step);
    return (step == 1) || (step == 2) || (step == 4);
  endfunction

  // Counter must be able to hold the final value N = width/step.
  function automatic int cnt_width(input int width, input int step);
    return $clog2(width / step + 1);
  endfunction

endpackage

// File: rtl/multiplier_iterative_param_if.sv
// Operand/result handshake bundle for multiplier_iterative_param.
interface multiplier_iterative_param_if #(
  parameter int WIDTH = 32
);
  logic               valid_in;
  logic               ready_in;
  logic               is_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               valid_out;
  logic               ready_out;
  logic [2*WIDTH-1:0] r;

  modport master (
    output valid_in, is_signed, a, b, ready_out,
    input  ready_in, valid_out, r
  );

  modport slave (
    input  valid_in, is_signed, a, b, ready_out,
    output ready_in, valid_out, r
  );
endinterface

// File: rtl/multiplier_iterative_param_step.sv
// One shift-add iteration: folds STEP multiplier bits into the accumulator.
module mul_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mp,
  input  logic [2*WIDTH-1:0] mc,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   mp_next,
  output logic [2*WIDTH-1:0] mc_next
);

  logic [2*WIDTH-1:0] partial;

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (mp[i]) partial = partial + (mc << i);
    end
    acc_next = acc + partial;
    mp_next  = mp >> STEP;
    mc_next  = mc << STEP;
  end

endmodule

// File: rtl/multiplier_iterative_param.sv
// Handshaked iterative multiplier: magnitudes are multiplied STEP bits per cycle,
// the sign is applied once on the final edge.
module multiplier_iterative_param
  import mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP       = 1,
  parameter int EARLY_EXIT = 0
) (
  input logic                    clk,
  input logic                    reset,
  multiplier_iterative_param_if.slave bus
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = cnt_width(WIDTH, STEP);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] N_C = CW'(N);

  if (!step_is_legal(STEP) || (WIDTH % STEP) != 0 || WIDTH < 4) begin : g_bad_params
    $error("multiplier_iterative_param: illegal WIDTH/STEP combination");
  end

  state_t          state, state_next;
  logic [PW-1:0]   acc, mc, acc_next, mc_next;
  logic [WIDTH-1:0] mp, mp_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            neg;
  logic            accept, finish;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [PW-1:0]   r_q;
  logic            valid_q;

  mul_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc      (acc),
    .mp       (mp),
    .mc       (mc),
    .acc_next (acc_next),
    .mp_next  (mp_next),
    .mc_next  (mc_next)
  );

  assign bus.ready_in  = (state == IDLE) || ((state == DONE) && bus.ready_out);
  assign bus.valid_out = valid_q;
  assign bus.r         = r_q;

  assign accept   = bus.valid_in && bus.ready_in;
  assign cnt_next = cnt + CW'(1);
  assign finish   = (state == BUSY) &&
                    ((cnt_next == N_C) || ((EARLY_EXIT != 0) && (mp_next == '0)));

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  assign a_abs = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = BUSY;
      BUSY: if (finish) state_next = DONE;
      DONE: if (bus.ready_out) state_next = bus.valid_in ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      r_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        mc  <= PW'(a_abs);
        mp  <= b_abs;
        acc <= '0;
        cnt <= '0;
        neg <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end else if (state == BUSY) begin
        acc <= acc_next;
        mc  <= mc_next;
        mp  <= mp_next;
        cnt <= cnt_next;
      end

      if (finish) begin
        r_q     <= neg ? -acc_next : acc_next;
        valid_q <= 1'b1;
      end else if ((state == DONE) && bus.ready_out) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_iterative_param.sv
// Directed bench for three multiplier configurations: STEP=1, STEP=4, early exit.
module tb_multiplier_iterative_param;

  logic        clk;
  logic        reset;
  logic [31:0] a_d, b_d;
  logic        sgn_d;
  logic [2:0]  vi, ro, ri, vo;
  logic [63:0] rr [3];

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  multiplier_iterative_param_if #(.WIDTH(32)) if_s1 ();
  multiplier_iterative_param_if #(.WIDTH(32)) if_s4 ();
  multiplier_iterative_param_if #(.WIDTH(32)) if_ee ();

  assign if_s1.a = a_d;  assign if_s1.b = b_d;  assign if_s1.is_signed = sgn_d;
  assign if_s4.a = a_d;  assign if_s4.b = b_d;  assign if_s4.is_signed = sgn_d;
  assign if_ee.a = a_d;  assign if_ee.b = b_d;  assign if_ee.is_signed = sgn_d;
  assign if_s1.valid_in = vi[0];  assign if_s1.ready_out = ro[0];
  assign if_s4.valid_in = vi[1];  assign if_s4.ready_out = ro[1];
  assign if_ee.valid_in = vi[2];  assign if_ee.ready_out = ro[2];
  assign ri = {if_ee.ready_in, if_s4.ready_in, if_s1.ready_in};
  assign vo = {if_ee.valid_out, if_s4.valid_out, if_s1.valid_out};
  assign rr[0] = if_s1.r;
  assign rr[1] = if_s4.r;
  assign rr[2] = if_ee.r;

  multiplier_iterative_param #(.WIDTH(32), .STEP(1), .EARLY_EXIT(0)) u_s1 (
    .clk(clk), .reset(reset), .bus(if_s1));
  multiplier_iterative_param #(.WIDTH(32), .STEP(4), .EARLY_EXIT(0)) u_s4 (
    .clk(clk), .reset(reset), .bus(if_s4));
  multiplier_iterative_param #(.WIDTH(32), .STEP(1), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .reset(reset), .bus(if_ee));

  typedef struct {
    int          sel;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic start_op(input int sel, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input string name);
    @(negedge clk);
    a_d = a; b_d = b; sgn_d = sgn;
    vi[sel] = 1'b1;
    chk({name, " ready_in idle"}, 64'(ri[sel]), 64'd1);
    @(posedge clk); #1;
    vi[sel] = 1'b0;
    chk({name, " ready_in busy"}, 64'(ri[sel]), 64'd0);
    // Changing operands mid-operation must not disturb the result.
    a_d = $urandom(); b_d = $urandom(); sgn_d = ~sgn;
  endtask

  task automatic wait_done(input int sel, input int exp_lat, input logic [63:0] exp_r,
                           input string name);
    int lat = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      lat++;
      if (vo[sel]) seen = 1'b1;
    end
    chk({name, " valid_out seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, " latency"}, 64'(lat), 64'(exp_lat));
      chk({name, " r"}, rr[sel], exp_r);
    end
  endtask

  initial begin
    vecs[0]  = '{0, 1'b0, 32'd3,         32'd5,         64'd15,                  32};
    vecs[1]  = '{0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32};
    vecs[2]  = '{0, 1'b1, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 32};
    vecs[3]  = '{0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32};
    vecs[4]  = '{0, 1'b1, 32'd7,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 32};
    vecs[5]  = '{0, 1'b0, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, 32};
    vecs[6]  = '{1, 1'b0, 32'd3,         32'd5,         64'd15,                  8};
    vecs[7]  = '{1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15,                  8};
    vecs[8]  = '{1, 1'b0, 32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780, 8};
    vecs[9]  = '{2, 1'b0, 32'd3,         32'd7,         64'd21,                  3};
    vecs[10] = '{2, 1'b0, 32'd5,         32'd0,         64'd0,                   1};
    vecs[11] = '{2, 1'b1, 32'd3,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 1};
    vecs[12] = '{2, 1'b0, 32'd1,         32'h8000_0000, 64'h0000_0000_8000_0000, 32};
    vecs[13] = '{2, 1'b1, 32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000, 1};

    reset = 1'b1;
    vi = '0; ro = '1; a_d = '0; b_d = '0; sgn_d = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset%0d ready_in", s), 64'(ri[s]), 64'd1);
      chk($sformatf("reset%0d valid_out", s), 64'(vo[s]), 64'd0);
      chk($sformatf("reset%0d r", s), rr[s], 64'd0);
    end
    #12;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].sel, vecs[i].sgn, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      wait_done(vecs[i].sel, vecs[i].lat, vecs[i].r, $sformatf("vec%0d", i));
    end

    // Backpressure: result held while the consumer stalls.
    ro[0] = 1'b0;
    start_op(0, 1'b0, 32'd9, 32'd9, "bp");
    wait_done(0, 32, 64'd81, "bp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d valid_out", c), 64'(vo[0]), 64'd1);
      chk($sformatf("bp hold%0d r", c), rr[0], 64'd81);
      chk($sformatf("bp hold%0d ready_in", c), 64'(ri[0]), 64'd0);
    end

    // Hand-off: release and present new operands on the same edge.
    @(negedge clk);
    ro[0] = 1'b1; a_d = 32'd2; b_d = 32'd7; sgn_d = 1'b0; vi[0] = 1'b1;
    #1;
    chk("handoff ready_in", 64'(ri[0]), 64'd1);
    @(posedge clk); #1;
    vi[0] = 1'b0;
    chk("handoff valid_out drop", 64'(vo[0]), 64'd0);
    chk("handoff busy ready_in", 64'(ri[0]), 64'd0);
    wait_done(0, 32, 64'd14, "handoff");
    @(posedge clk); #1;
    chk("idle valid_out", 64'(vo[0]), 64'd0);
    chk("idle r retained", rr[0], 64'd14);

    // Asynchronous reset mid-operation.
    start_op(0, 1'b0, 32'd3, 32'd3, "rst");
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset valid_out", 64'(vo[0]), 64'd0);
    chk("midreset r", rr[0], 64'd0);
    chk("midreset ready_in", 64'(ri[0]), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    start_op(0, 1'b0, 32'd6, 32'd7, "post");
    wait_done(0, 32, 64'd42, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
